// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
//   Data-memory responder for the single-cycle RISC-V core. Services the
//   decoder's load/store requests against an internal word-organised RAM,
//   with byte/halfword/word write masking, sign-extending loads, and a fixed
//   number of wait states during which the core is held through mem_stall.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   MemRead     : load request (level)
//   MemWrite    : store request (level)
//   L_type      : 00 lb, 01 lh, 10/11 lw
//   S_type      : 00 sb, 01 sh, 10/11 sw
//   addr        : byte address (ALU result)
//   wdata       : store data (rs2)
//   rdata       : registered, extended load result
//   mem_stall   : core must hold PC and pipeline inputs while high
//   access_err  : misaligned or conflicting request, valid in the DONE cycle
//
// Handshake: the core raises MemRead/MemWrite and holds them, with addr,
// wdata and type stable, for as long as mem_stall is high. The cycle in which
// mem_stall is low after a request (DONE) is the completion cycle: rdata and
// access_err are valid there and the core advances at the end of it. Inputs
// present in DONE are ignored; a request present in the following IDLE cycle
// is accepted immediately.
// ----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  L_type,
  input  logic [1:0]  S_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_stall,
  output logic        access_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;

  // Latched request
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_is_write;

  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_req;
  logic [1:0]    w_size_in;
  logic          w_misaligned;
  logic          w_illegal;
  logic          w_accept;
  logic          w_reject;
  logic          w_commit;
  logic          w_stall;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_val;

  // Upper address bits are deliberately ignored so accesses wrap.
  logic          w_unused_addr;
  assign w_unused_addr = &{1'b0, addr[31:AW+2]};

  // ---------------------------------------------------------------- request
  assign w_req     = MemRead | MemWrite;
  assign w_size_in = MemRead ? L_type : S_type;

  always_comb begin
    w_misaligned = 1'b0;
    case (w_size_in)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = addr[0];
      default: w_misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  assign w_illegal = (MemRead & MemWrite) | w_misaligned;
  assign w_accept  = (r_state == S_IDLE) & w_req & ~w_illegal;
  assign w_reject  = (r_state == S_IDLE) & w_req & w_illegal;
  // Commit edge: leaving WAIT with the counter exhausted.
  assign w_commit  = (r_state == S_WAIT) & (r_cnt == 4'd0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          if (w_illegal) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stall must release the instant reset asserts, so gate it with rst_n.
  assign mem_stall = rst_n & w_stall;

  // ---------------------------------------------------------------- latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= 2'b00;
      r_is_write <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= addr[AW+1:0];
      r_wdata    <= wdata;
      r_size     <= w_size_in;
      r_is_write <= MemWrite;
    end
  end

  // ---------------------------------------------------------------- RAM
  assign w_idx   = r_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = r_wdata;
    case (r_size)
      2'b00: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
      end
    endcase
  end

  // No reset: RAM contents are not cleared. The commit is qualified by the
  // reset-cleared FSM state, so an aborted access never writes.
  always_ff @(posedge clk) begin
    if (w_commit && r_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- load path
  always_comb begin
    w_byte = w_rword[7:0];
    case (r_addr[1:0])
      2'b00: w_byte = w_rword[7:0];
      2'b01: w_byte = w_rword[15:8];
      2'b10: w_byte = w_rword[23:16];
      2'b11: w_byte = w_rword[31:24];
      default: w_byte = w_rword[7:0];
    endcase
  end

  assign w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load_val = w_rword;
    case (r_size)
      2'b00:   w_load_val = {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_val = {{16{w_half[15]}}, w_half};
      default: w_load_val = w_rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      // access_err is high only in the DONE cycle following a rejection.
      r_err <= w_reject;
      if (w_reject) begin
        r_rdata <= '0;
      end else if (w_commit && !r_is_write) begin
        r_rdata <= w_load_val;
      end
    end
  end

  assign rdata      = r_rdata;
  assign access_err = r_err;

endmodule
